// File: rtl/cpu_types_pkg.sv
// Shared types for the RAM arbiter: RAM handshake states, word type,
// arbiter FSM encoding, grant-id constants and arbiter sizing constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ERR   = 2'd2
  } arb_state_t;

  // gnt_id = {class, core}; class 1 is the data class
  localparam logic [1:0] GNT_I0 = 2'b00;
  localparam logic [1:0] GNT_I1 = 2'b01;
  localparam logic [1:0] GNT_D0 = 2'b10;
  localparam logic [1:0] GNT_D1 = 2'b11;

  // number of cores; the arbiter is built for exactly two
  localparam int CPUS = 2;

  // consecutive data grants tolerated while an instruction fill waits
  localparam logic [3:0] STARVE_MAX = 4'd8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: the core named by ptr wins when it requests,
// otherwise the other core wins. valid is low when nobody requests.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;
  assign idx   = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/ram_arbiter.sv
// Registered two-core arbiter between icache/dcache request ports and the
// single RAM port. Data requests beat instruction requests; each class
// round-robins between core 0 and core 1.
//
// Handshake: a requester raises iREN/dREN/dWEN and holds it, together with
// its address/data, while its wait bit is high. The wait bit drops for
// exactly one cycle, combinationally with ramstate==ACCESS, and that is the
// cycle the load data is valid. Dropping the request before ACCESS abandons
// the access without moving the round-robin pointer.
//
// Optional feature: define ARB_STARVE_EN to let a starved instruction fill
// through after STARVE_MAX back-to-back data grants.
module ram_arbiter
  import cpu_types_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  input  ramstate_t             ramstate,
  input  logic [31:0]           ramload,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic [1:0]            gnt_id,
  output logic [1:0]            dbg_state
);

  arb_state_t      state_q;
  logic            gnt_cls_q;   // 1 = data class
  logic            gnt_core_q;
  logic            wr_q;        // granted data access is a write
  logic            ren_q;
  logic            wen_q;
  logic            rr_d_q;
  logic            rr_i_q;

  logic [CPUS-1:0] d_req;
  logic            d_valid;
  logic            d_idx;
  logic            i_valid;
  logic            i_idx;
  logic            take_i;
  logic            held;
  logic            in_grant;
  logic            done;
  logic            starve_force;

  assign d_req = dREN | dWEN;

  rr_pick2 u_pick_d (
    .req   (d_req),
    .ptr   (rr_d_q),
    .valid (d_valid),
    .idx   (d_idx)
  );

  rr_pick2 u_pick_i (
    .req   (iREN),
    .ptr   (rr_i_q),
    .valid (i_valid),
    .idx   (i_idx)
  );

  // instruction class wins only when no data request exists, or when
  // the starvation guard forces it through
  assign take_i = i_valid && (!d_valid || starve_force);

  // the granted requester is still asking for the operation it was given
  assign held = gnt_cls_q ? (wr_q ? dWEN[gnt_core_q] : dREN[gnt_core_q])
                          : iREN[gnt_core_q];

  assign in_grant = (state_q == GRANT);
  assign done     = in_grant && (ramstate == ACCESS);

`ifdef ARB_STARVE_EN
  logic [3:0] starve_q;

  // count data grants made while an instruction fill is waiting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= 4'd0;
    end else if (!(|iREN)) begin
      starve_q <= 4'd0;
    end else if (state_q == IDLE && ramstate != ERROR) begin
      if (take_i) begin
        starve_q <= 4'd0;
      end else if (d_valid && starve_q != 4'hF) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

  assign starve_force = (starve_q >= STARVE_MAX);
`else
  assign starve_force = 1'b0;
`endif

  // arbitration FSM with registered grant, strobes and pointers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      gnt_cls_q  <= 1'b0;
      gnt_core_q <= 1'b0;
      wr_q       <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      rr_d_q     <= 1'b0;
      rr_i_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ramstate == ERROR) begin
            state_q <= ERR;
          end else if (take_i) begin
            state_q    <= GRANT;
            gnt_cls_q  <= 1'b0;
            gnt_core_q <= i_idx;
            wr_q       <= 1'b0;
            ren_q      <= 1'b1;
            wen_q      <= 1'b0;
          end else if (d_valid) begin
            // a write from the same core goes first; its read re-arbitrates later
            state_q    <= GRANT;
            gnt_cls_q  <= 1'b1;
            gnt_core_q <= d_idx;
            wr_q       <= dWEN[d_idx];
            ren_q      <= !dWEN[d_idx];
            wen_q      <= dWEN[d_idx];
          end
        end
        GRANT: begin
          if (ramstate == ERROR) begin
            state_q <= ERR;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
          end else if (ramstate == ACCESS) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            if (gnt_cls_q) begin
              rr_d_q <= ~gnt_core_q;
            end else begin
              rr_i_q <= ~gnt_core_q;
            end
          end else if (!held) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
          end
        end
        ERR: begin
          ren_q <= 1'b0;
          wen_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
        end
      endcase
    end
  end

  // RAM address/data steering and one-cycle wait release on ACCESS
  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    if (in_grant) begin
      ramaddr = gnt_cls_q ? daddr[gnt_core_q] : iaddr[gnt_core_q];
      if (gnt_cls_q && wr_q) begin
        ramstore = dstore[gnt_core_q];
      end
    end
    if (done) begin
      if (gnt_cls_q) begin
        dwait[gnt_core_q] = 1'b0;
        dload[gnt_core_q] = ramload;
      end else begin
        iwait[gnt_core_q] = 1'b0;
        iload[gnt_core_q] = ramload;
      end
    end
  end

  assign ramREN    = ren_q;
  assign ramWEN    = wen_q;
  assign gnt_id    = {gnt_cls_q, gnt_core_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by
// randomized request patterns, each transaction checked against a
// transaction-level model of the arbitration rules.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iren, dren, dwen;
  logic [1:0][31:0] iaddr, daddr, dstore;
  ramstate_t        ramstate;
  logic [31:0]      ramload;
  logic [31:0]      ramaddr, ramstore;
  logic             ramren, ramwen;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic [1:0]       gnt_id, dbg_state;

  int checks   = 0;
  int failures = 0;

  // model state: preferred core per class and data-grant streak length
  int ptr_d, ptr_i, starve;

  ram_arbiter dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iren),
    .dREN      (dren),
    .dWEN      (dwen),
    .iaddr     (iaddr),
    .daddr     (daddr),
    .dstore    (dstore),
    .ramstate  (ramstate),
    .ramload   (ramload),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramREN    (ramren),
    .ramWEN    (ramwen),
    .iwait     (iwait),
    .dwait     (dwait),
    .iload     (iload),
    .dload     (dload),
    .gnt_id    (gnt_id),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    iren = '0; dren = '0; dwen = '0;
    ramstate = FREE; ramload = '0;
    ptr_d = 0; ptr_i = 0; starve = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  // who should win the next IDLE arbitration, as {class, core}
  function automatic logic [1:0] predict();
    logic [1:0] dq;
    bit         force_i;
    int         c;
    dq      = dren | dwen;
    force_i = 1'b0;
`ifdef ARB_STARVE_EN
    force_i = (starve >= 8) && (iren != 2'b00);
`endif
    if (dq != 2'b00 && !force_i) begin
      c = dq[ptr_d] ? ptr_d : 1 - ptr_d;
      return {1'b1, c[0]};
    end
    c = iren[ptr_i] ? ptr_i : 1 - ptr_i;
    return {1'b0, c[0]};
  endfunction

  // one full transaction from IDLE: grant, busy cycles, ACCESS, back to IDLE;
  // the served request is then dropped like a cache would
  task automatic run_txn(input int busy, output logic [1:0] g);
    logic [1:0]       eg, ew_i, ew_d;
    logic [1:0][31:0] el_i, el_d;
    logic             wr;
    logic [31:0]      ea, es;
    int               c;
    eg = predict();
    c  = eg[0];
    wr = eg[1] && dwen[c];
    ea = eg[1] ? daddr[c] : iaddr[c];
    es = wr ? dstore[c] : 32'd0;
    if (iren == 2'b00 || !eg[1]) starve = 0;
    else starve++;
    tick();
    g = gnt_id;
    check("gnt_id", gnt_id, eg);
    check("state_grant", dbg_state, GRANT);
    check("ramREN", ramren, !wr);
    check("ramWEN", ramwen, wr);
    check("ramaddr", ramaddr, ea);
    check("ramstore", ramstore, es);
    for (int k = 0; k < busy; k++) begin
      ramstate = BUSY;
      #1;
      check("busy_waits", {iwait, dwait}, 4'hF);
      tick();
    end
    ramstate = ACCESS;
    ramload  = $urandom;
    #1;
    ew_i = 2'b11; ew_d = 2'b11; el_i = '0; el_d = '0;
    if (eg[1]) begin
      ew_d[c] = 1'b0;
      el_d[c] = ramload;
    end else begin
      ew_i[c] = 1'b0;
      el_i[c] = ramload;
    end
    check("access_iwait", iwait, ew_i);
    check("access_dwait", dwait, ew_d);
    check("access_iload", iload, el_i);
    check("access_dload", dload, el_d);
    tick();
    ramstate = FREE;
    check("done_state", dbg_state, IDLE);
    check("done_strobes", {ramren, ramwen}, 2'b00);
    check("done_waits", {iwait, dwait}, 4'hF);
    check("done_loads", {iload, dload}, 128'd0);
    if (eg[1]) begin
      if (wr) dwen[c] = 1'b0;
      else    dren[c] = 1'b0;
      ptr_d = 1 - c;
    end else begin
      iren[c] = 1'b0;
      ptr_i   = 1 - c;
    end
  endtask

  logic [1:0] g;
  logic [1:0] exp_rr [4];

  initial begin
    // reset values, checked before any clock edge
    nRST = 1'b0;
    iren = '0; dren = '0; dwen = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    #2;
    check("rst_strobes", {ramren, ramwen}, 2'b00);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_loads", {iload, dload}, 128'd0);
    check("rst_gnt_id", gnt_id, 2'b00);
    check("rst_state", dbg_state, IDLE);
    do_reset();

    // single instruction read, ACCESS two cycles after grant
    iaddr[0] = 32'h100;
    iren = 2'b01;
    run_txn(1, g);
    check("t1_gnt", g, GNT_I0);

    // data beats instruction, then the instruction is served
    iren = 2'b10; dren = 2'b01;
    daddr[0] = 32'h2000; iaddr[1] = 32'h300;
    run_txn(0, g);
    check("t2_first", g, GNT_D0);
    run_txn(0, g);
    check("t2_second", g, GNT_I1);

    // round robin within the data class from a fresh pointer
    do_reset();
    exp_rr = '{GNT_D0, GNT_D1, GNT_D0, GNT_D1};
    for (int k = 0; k < 4; k++) begin
      dren = 2'b11;
      daddr[0] = $urandom; daddr[1] = $urandom;
      run_txn($urandom_range(0, 2), g);
      check("t3_rr", g, exp_rr[k]);
    end
    dren = '0;

    // same-core write then read
    dstore[1] = 32'hDEADBEEF;
    daddr[1]  = 32'h4000;
    dwen = 2'b10; dren = 2'b10;
    run_txn(1, g);
    check("t4_write_gnt", g, GNT_D1);
    run_txn(0, g);
    check("t4_read_gnt", g, GNT_D1);

    // withdrawal mid-grant: strobe drops, no wait release, pointer kept
    iren = 2'b01; dren = '0; dwen = '0;
    iaddr[0] = 32'h180;
    tick();
    check("wd_gnt", gnt_id, GNT_I0);
    check("wd_ren", ramren, 1'b1);
    ramstate = BUSY;
    iren = 2'b00;
    starve = 0;
    #1;
    check("wd_waits_now", iwait, 2'b11);
    tick();
    ramstate = FREE;
    check("wd_ren_off", ramren, 1'b0);
    check("wd_iwait", iwait, 2'b11);
    check("wd_state", dbg_state, IDLE);
    iren = 2'b11;
    iaddr[1] = 32'h1C0;
    run_txn(0, g);
    check("wd_ptr_kept", g, GNT_I0);
    iren = '0;

    // randomized request mixes
    for (int n = 0; n < 40; n++) begin
      if ((iren | dren | dwen) == 2'b00 || $urandom_range(0, 2) == 0) begin
        iren = iren | 2'($urandom_range(0, 3));
        dren = dren | 2'($urandom_range(0, 3));
        dwen = dwen | 2'($urandom_range(0, 3));
      end
      if ((iren | dren | dwen) == 2'b00) iren = 2'b01;
      for (int c = 0; c < 2; c++) begin
        iaddr[c]  = $urandom;
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
      end
      run_txn($urandom_range(0, 3), g);
    end

    // starvation guard: data streak with an instruction fill waiting
    do_reset();
    for (int k = 0; k < 9; k++) begin
      dren = 2'b11;
      iren = 2'b01;
      run_txn(0, g);
`ifdef ARB_STARVE_EN
      check("starve_cls", g[1], (k < 8));
`else
      check("strict_cls", g[1], 1'b1);
`endif
    end

    // asynchronous reset in the middle of a grant
    do_reset();
    iren = 2'b01;
    iaddr[0] = 32'h500;
    tick();
    check("mr_ren", ramren, 1'b1);
    check("mr_addr", ramaddr, 32'h500);
    #2;
    nRST = 1'b0;
    #1;
    check("mr_strobes", {ramren, ramwen}, 2'b00);
    check("mr_ramaddr", ramaddr, 32'd0);
    check("mr_state", dbg_state, IDLE);
    check("mr_waits", {iwait, dwait}, 4'hF);
    do_reset();

    // RAM error is sticky until reset
    iren = 2'b01;
    tick();
    check("er_gnt_ren", ramren, 1'b1);
    ramstate = ERROR;
    tick();
    ramstate = ACCESS;
    #1;
    check("er_state", dbg_state, ERR);
    check("er_strobes", {ramren, ramwen}, 2'b00);
    check("er_waits", {iwait, dwait}, 4'hF);
    ramstate = FREE;
    tick();
    tick();
    check("er_sticky", dbg_state, ERR);
    check("er_sticky_ren", ramren, 1'b0);
    do_reset();
    check("er_cleared", dbg_state, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
